// File: rtl/instr_encoder_loader.sv
// Program loader for the single-cycle CPU's instruction memory.
// Takes decoded instruction fields over valid/ready and encodes them into an
// RV32I word. Words are written to consecutive memory slots until memory is full.
// Each bundle takes three cycles: IDLE accepts it, ENC builds the word and
// checks legality, and WRITE commits it. The write strobe is registered, so
// mem_we_o rises two cycles after the acceptance edge.

module instr_encoder_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [2:0]        class_i,
   input  logic [2:0]        funct3_i,
   input  logic              alt_i,
   input  logic [4:0]        rd_i,
   input  logic [4:0]        rs1_i,
   input  logic [4:0]        rs2_i,
   input  logic [12:0]       imm_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              err_o,
   output logic              full_o,
   output logic [ADDR_W:0]   count_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENC   = 2'd1,
      ST_WRITE = 2'd2,
      ST_FULL  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
   localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   // Format classes: 0=R, 1=I-ALU, 2=LD, 3=S, 4=B.
   function automatic logic [31:0] encode(
      input logic [2:0]  cls,
      input logic [2:0]  f3,
      input logic        alt,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [12:0] imm
   );
      logic [31:0] w;
      w = 32'd0;
      case (cls)
         3'd0:    w = {1'b0, alt, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
         3'd1:    w = {imm[11:0], rs1, f3, rd, 7'b0010011};
         3'd2:    w = {imm[11:0], rs1, f3, rd, 7'b0000011};
         3'd3:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
         3'd4:    w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   // Classes 5-7 do not exist. A branch offset must be even.
   function automatic logic is_illegal(input logic [2:0] cls, input logic imm0);
      return (cls > 3'd4) || ((cls == 3'd4) && imm0);
   endfunction

   state_t            state_q, state_d;
   logic [2:0]        cls_q, cls_d;
   logic [2:0]        f3_q, f3_d;
   logic              alt_q, alt_d;
   logic [4:0]        rd_q, rd_d;
   logic [4:0]        rs1_q, rs1_d;
   logic [4:0]        rs2_q, rs2_d;
   logic [12:0]       imm_q, imm_d;
   logic [31:0]       word_q, word_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, full_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              err_q, err_d;

   assign ready_o     = (state_q == ST_IDLE) && !rst_i && !clear_i;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign err_o       = err_q;
   assign full_o      = full_q;
   assign count_o     = count_q;

   // Next-state and output logic; clear_i overrides every other event.
   always_comb begin
      state_d     = state_q;
      cls_d       = cls_q;
      f3_d        = f3_q;
      alt_d       = alt_q;
      rd_d        = rd_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      imm_d       = imm_q;
      word_d      = word_q;
      ptr_d       = ptr_q;
      count_d     = count_q;
      full_d      = full_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      err_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (valid_i && ready_o) begin
               cls_d   = class_i;
               f3_d    = funct3_i;
               alt_d   = alt_i;
               rd_d    = rd_i;
               rs1_d   = rs1_i;
               rs2_d   = rs2_i;
               imm_d   = imm_i;
               state_d = ST_ENC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ENC: begin
            word_d = encode(cls_q, f3_q, alt_q, rd_q, rs1_q, rs2_q, imm_q);
            if (is_illegal(cls_q, imm_q[0])) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = word_q;
            count_d     = count_q + CNT_ONE;
            // The pointer parks on the last slot; only clear_i reopens memory.
            if (ptr_q == PTR_MAX) begin
               full_d  = 1'b1;
               state_d = ST_FULL;
            end else begin
               ptr_d   = ptr_q + PTR_ONE;
               state_d = ST_IDLE;
            end
         end
         ST_FULL: begin
            state_d = ST_FULL;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (clear_i) begin
         state_d     = ST_IDLE;
         ptr_d       = {ADDR_W{1'b0}};
         count_d     = {(ADDR_W+1){1'b0}};
         full_d      = 1'b0;
         mem_we_d    = 1'b0;
         err_d       = 1'b0;
         mem_addr_d  = {ADDR_W{1'b0}};
         mem_wdata_d = 32'd0;
      end else begin
         state_d = state_d;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cls_q       <= 3'd0;
         f3_q        <= 3'd0;
         alt_q       <= 1'b0;
         rd_q        <= 5'd0;
         rs1_q       <= 5'd0;
         rs2_q       <= 5'd0;
         imm_q       <= 13'd0;
         word_q      <= 32'd0;
         ptr_q       <= {ADDR_W{1'b0}};
         count_q     <= {(ADDR_W+1){1'b0}};
         full_q      <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cls_q       <= cls_d;
         f3_q        <= f3_d;
         alt_q       <= alt_d;
         rd_q        <= rd_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         imm_q       <= imm_d;
         word_q      <= word_d;
         ptr_q       <= ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader with a four-word memory (ADDR_W=2).
// Directed vectors come from a table. Random traffic is compared against a
// transaction-level model that tracks acceptances, retirements and the pointer.

module tb_instr_encoder_loader;
   localparam int AW = 2;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1, clear_i = 1'b0, valid_i = 1'b0;
   logic          ready_o;
   logic [2:0]    class_i = 3'd0, funct3_i = 3'd0;
   logic          alt_i = 1'b0;
   logic [4:0]    rd_i = 5'd0, rs1_i = 5'd0, rs2_i = 5'd0;
   logic [12:0]   imm_i = 13'd0;
   logic          mem_we_o, err_o, full_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o;
   logic [AW:0]   count_o;

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_W(AW)) dut (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .valid_i(valid_i),
      .ready_o(ready_o), .class_i(class_i), .funct3_i(funct3_i), .alt_i(alt_i),
      .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .err_o(err_o), .full_o(full_o), .count_o(count_o)
   );

   typedef struct {
      logic [2:0]  cls;
      logic [2:0]  f3;
      logic        alt;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [12:0] imm;
      bit          legal;
      logic [31:0] word;
      int          addr;
   } vec_t;

   vec_t tbl [8];

   int checks = 0;
   int failures = 0;

   // Reference model state
   int          cyc = 0;
   bit          m_pend = 1'b0;
   bit          m_legal = 1'b0;
   logic [31:0] m_word = 32'd0;
   int          m_acc = 0;
   bit          m_full = 1'b0;
   int          m_ptr = 0;
   int          m_count = 0;
   bit          e_we = 1'b0, e_err = 1'b0;
   int          e_addr = 0;
   logic [31:0] e_wdata = 32'd0;
   bit          acc_flag = 1'b0;

   // Observations for the directed sequences
   int          we_seen = 0, err_seen = 0, last_a = -1;
   logic [31:0] last_w = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_word(input vec_t v);
      logic [31:0] imm, base;
      imm  = 32'(v.imm);
      base = (32'(v.rd) << 7) | (32'(v.f3) << 12) | (32'(v.rs1) << 15);
      case (v.cls)
         3'd0: return 32'h33 | base | (32'(v.rs2) << 20) | (32'(v.alt) << 30);
         3'd1: return 32'h13 | base | ((imm & 32'hFFF) << 20);
         3'd2: return 32'h03 | base | ((imm & 32'hFFF) << 20);
         3'd3: return 32'h23 | ((imm & 32'h1F) << 7) | (32'(v.f3) << 12) | (32'(v.rs1) << 15)
                      | (32'(v.rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
         3'd4: return 32'h63 | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                      | (32'(v.f3) << 12) | (32'(v.rs1) << 15) | (32'(v.rs2) << 20)
                      | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit m_rdy();
      return !m_pend && !m_full && !rst_i && !clear_i;
   endfunction

   function automatic vec_t cur_inputs();
      vec_t v;
      v.cls = class_i; v.f3 = funct3_i; v.alt = alt_i; v.rd = rd_i;
      v.rs1 = rs1_i; v.rs2 = rs2_i; v.imm = imm_i;
      v.legal = 1'b0; v.word = 32'd0; v.addr = 0;
      return v;
   endfunction

   // Advances the model by one clock edge, using the inputs that edge samples.
   task automatic model_step();
      bit rdy;
      vec_t v;
      rdy = m_rdy();
      e_we = 1'b0;
      e_err = 1'b0;
      if (rst_i || clear_i) begin
         m_pend = 1'b0; m_full = 1'b0; m_ptr = 0; m_count = 0;
         e_addr = 0; e_wdata = 32'd0;
      end else begin
         if (m_pend && !m_legal && cyc == m_acc + 1) begin
            e_err = 1'b1;
            m_pend = 1'b0;
         end else if (m_pend && m_legal && cyc == m_acc + 2) begin
            e_we = 1'b1;
            e_addr = m_ptr;
            e_wdata = m_word;
            m_count++;
            if (m_ptr == DEPTH - 1) m_full = 1'b1;
            else m_ptr++;
            m_pend = 1'b0;
         end
         if (rdy && valid_i) begin
            v = cur_inputs();
            m_pend = 1'b1;
            m_acc = cyc;
            m_legal = (v.cls <= 3'd4) && !(v.cls == 3'd4 && v.imm[0]);
            m_word = ref_word(v);
            acc_flag = 1'b1;
         end
      end
      cyc++;
   endtask

   task automatic tick();
      #1;
      chk("ready", 32'(ready_o), 32'(m_rdy()));
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("mem_we", 32'(mem_we_o), 32'(e_we));
      chk("err", 32'(err_o), 32'(e_err));
      chk("full", 32'(full_o), 32'(m_full));
      chk("count", 32'(count_o), 32'(m_count));
      chk("addr", 32'(mem_addr_o), 32'(e_addr));
      chk("wdata", mem_wdata_o, e_wdata);
      if (mem_we_o === 1'b1) begin
         we_seen++;
         last_w = mem_wdata_o;
         last_a = int'(mem_addr_o);
      end
      if (err_o === 1'b1) err_seen++;
   endtask

   task automatic drive(input vec_t v);
      class_i = v.cls; funct3_i = v.f3; alt_i = v.alt; rd_i = v.rd;
      rs1_i = v.rs1; rs2_i = v.rs2; imm_i = v.imm;
   endtask

   task automatic send(input vec_t v, input bit keep_valid);
      int n;
      we_seen = 0; err_seen = 0; last_a = -1; last_w = 32'hxxxxxxxx;
      drive(v);
      valid_i = 1'b1;
      acc_flag = 1'b0;
      n = 0;
      while (!acc_flag && n < 20) begin tick(); n++; end
      if (!acc_flag) chk("accept_timeout", 32'd0, 32'd1);
      if (!keep_valid) valid_i = 1'b0;
      n = 0;
      while (m_pend && n < 10) begin tick(); n++; end
   endtask

   task automatic check_vec(input string name, input vec_t v);
      if (v.legal) begin
         chk({name, "_word"}, last_w, v.word);
         chk({name, "_addr"}, 32'(last_a), 32'(v.addr));
         chk({name, "_we_pulses"}, 32'(we_seen), 32'd1);
      end else begin
         chk({name, "_err_pulses"}, 32'(err_seen), 32'd1);
         chk({name, "_no_write"}, 32'(we_seen), 32'd0);
      end
   endtask

   initial begin
      int n;
      int saved_count;
      tbl[0] = '{3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'h0000, 1'b1, 32'h002081B3, 0};
      tbl[1] = '{3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 13'h0000, 1'b1, 32'h402081B3, 1};
      tbl[2] = '{3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 13'h0FFF, 1'b1, 32'hFFF00293, 2};
      tbl[3] = '{3'd2, 3'd2, 1'b0, 5'd6, 5'd2, 5'd0, 13'h0008, 1'b1, 32'h00812303, 3};
      tbl[4] = '{3'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd6, 13'h000C, 1'b1, 32'h00612623, 0};
      tbl[5] = '{3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b1, 32'hFE208CE3, 1};
      tbl[6] = '{3'd6, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 13'h0000, 1'b0, 32'h00000000, 0};
      tbl[7] = '{3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'h0005, 1'b0, 32'h00000000, 0};

      // Reset
      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      tick();

      // Directed table: the first four words fill memory, then clear and continue.
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            chk("full_after_4", 32'(full_o), 32'd1);
            clear_i = 1'b1; tick(); clear_i = 1'b0;
            chk("count_after_clear", 32'(count_o), 32'd0);
         end
         send(tbl[i], 1'b0);
         check_vec($sformatf("vec%0d", i), tbl[i]);
      end
      tick();
      chk("ready_after_illegal", 32'(ready_o), 32'd1);
      chk("count_after_illegal", 32'(count_o), 32'd2);

      // Fill the remaining slots with valid_i held high, then offer a fifth bundle.
      send(tbl[0], 1'b1);
      send(tbl[1], 1'b1);
      chk("full_held", 32'(full_o), 32'd1);
      drive(tbl[2]);
      acc_flag = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("fifth_not_accepted", 32'(acc_flag), 32'd0);
      chk("count_full", 32'(count_o), 32'(DEPTH));
      valid_i = 1'b0;
      clear_i = 1'b1; tick(); clear_i = 1'b0;
      send(tbl[2], 1'b0);
      chk("after_clear_addr", 32'(last_a), 32'd0);

      // rst_i while the bundle is in ENC
      drive(tbl[3]); valid_i = 1'b1; acc_flag = 1'b0; n = 0;
      while (!acc_flag && n < 10) begin tick(); n++; end
      valid_i = 1'b0; rst_i = 1'b1; we_seen = 0;
      tick();
      rst_i = 1'b0;
      tick(); tick(); tick();
      chk("rst_enc_no_write", 32'(we_seen), 32'd0);
      send(tbl[0], 1'b0);
      chk("rst_enc_next_addr", 32'(last_a), 32'd0);

      // clear_i at the edge into WRITE and at the edge out of WRITE
      for (int off = 1; off <= 2; off++) begin
         drive(tbl[1]); valid_i = 1'b1; acc_flag = 1'b0; n = 0;
         while (!acc_flag && n < 10) begin tick(); n++; end
         valid_i = 1'b0; we_seen = 0;
         for (int k = 1; k < off; k++) tick();
         clear_i = 1'b1; tick(); clear_i = 1'b0;
         tick(); tick();
         chk($sformatf("clear_off%0d_no_write", off), 32'(we_seen), 32'd0);
         chk($sformatf("clear_off%0d_count", off), 32'(count_o), 32'd0);
      end
      send(tbl[4], 1'b0);
      chk("clear_next_addr", 32'(last_a), 32'd0);

      // Random traffic against the model
      saved_count = checks;
      for (int i = 0; i < 3000; i++) begin
         class_i  = 3'($urandom_range(0, 7));
         funct3_i = 3'($urandom);
         alt_i    = 1'($urandom);
         rd_i     = 5'($urandom);
         rs1_i    = 5'($urandom);
         rs2_i    = 5'($urandom);
         imm_i    = 13'($urandom);
         valid_i  = ($urandom_range(0, 3) != 0);
         clear_i  = ($urandom_range(0, 39) == 0);
         rst_i    = ($urandom_range(0, 149) == 0);
         tick();
      end
      rst_i = 1'b0; clear_i = 1'b0; valid_i = 1'b0;
      tick();
      chk("random_ran", 32'(checks > saved_count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the control decoder. Accepts decoded instruction fields (format class, registers, funct bits, immediate) over a valid/ready handshake.
- Encodes the fields into a 32-bit RV32I instruction word and writes that word into instruction memory at a sequential write pointer.
- Used to load programs into instruction memory for the single-cycle CPU during bring-up and test.

Parameters:
- ADDR_W, 8, width of the instruction-memory word index; depth = 2^ADDR_W words.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- clear_i  in  1  synchronous restart: pointer and count to 0; aborts any in-flight instruction.
- valid_i  in  1  field bundle valid.
- ready_o  out  1  block can accept a bundle.
- class_i  in  3  format class: 0=R, 1=I-ALU, 2=LD, 3=S, 4=B; 5-7 are illegal.
- funct3_i  in  3  funct3 field.
- alt_i  in  1  R only: sets instr[30] (funct7=0100000); otherwise ignored.
- rd_i  in  5  destination register.
- rs1_i  in  5  source register 1.
- rs2_i  in  5  source register 2.
- imm_i  in  13  immediate. I/LD/S use [11:0]; B uses [12:1], and [0] must be 0.
- mem_we_o  out  1  instruction-memory write strobe.
- mem_addr_o  out  ADDR_W  word index being written.
- mem_wdata_o  out  32  encoded instruction.
- err_o  out  1  one-cycle pulse: illegal bundle dropped.
- full_o  out  1  memory full.
- count_o  out  ADDR_W+1  number of words written since reset/clear.

Behaviour:
- Reset (rst_i=1 at an edge):
  - State to IDLE; pointer to 0.
  - count_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, err_o=0, full_o=0.
  - ready_o=0 while rst_i is high.
- rst_i has priority over clear_i. clear_i has priority over all other events. Both abort ENC/WRITE with no write issued.
- FSM states: IDLE, ENC, WRITE, FULL.
  - ready_o = (state==IDLE) && !rst_i && !clear_i.
  - IDLE: on valid_i && ready_o, latch all fields, go to ENC. With valid_i low, stay in IDLE.
  - ENC: build the word into a register and run the legality check.
    - Illegal means class 5-7, or class 4 with imm_i[0]=1.
    - If illegal: err_o=1 for the next cycle only, go to IDLE, nothing written.
    - If legal: go to WRITE.
  - WRITE: mem_we_o=1 for exactly this cycle; mem_addr_o=pointer; mem_wdata_o=encoded word. Then pointer+1 and count+1.
    - If the pointer was 2^ADDR_W-1: go to FULL, full_o=1.
    - Otherwise go to IDLE.
  - FULL: ready_o=0 and valid_i is ignored. Stay until clear_i; on clear, full_o=0 and go to IDLE.
- Latency: acceptance edge to mem_we_o high is 2 cycles. Throughput is one instruction per 3 cycles.
- mem_addr_o and mem_wdata_o hold their last values when mem_we_o=0.
- Pointer never wraps: count_o saturates at 2^ADDR_W, reached only via FULL.
- Encoding (opcode in [6:0]):
  - R: {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 0110011}.
  - I-ALU: {imm[11:0], rs1, f3, rd, 0010011}.
  - LD: {imm[11:0], rs1, f3, rd, 0000011}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}.
  - Fields not used by a format are ignored: rs2 for I/LD, rd for S/B, imm[12] for non-B formats.

Test Plan:
- Reset, then R bundle rd=3, rs1=1, rs2=2, f3=0, alt=0 -> 2 cycles after acceptance: mem_we_o=1, addr=0, wdata=0x002081B3; count_o=1. Next R bundle with alt=1 -> addr=1, wdata=0x402081B3.
- I-ALU rd=5, rs1=0, imm=0xFFF -> 0xFFF00293. LD f3=2, rd=6, rs1=2, imm=8 -> 0x00812303. S f3=2, rs2=6, rs1=2, imm=12 -> 0x00612623. B f3=0, rs1=1, rs2=2, imm=0x1FF8 -> 0xFE208CE3. Addresses increment by 1 each write.
- Illegal class 6, then B with imm=0x0005 -> err_o pulses once per bundle, mem_we_o stays 0, count_o unchanged, ready_o returns to 1.
- ADDR_W=2, four legal bundles with valid_i held high -> writes at addr 0,1,2,3; full_o=1 after the 4th write; ready_o=0; a 5th bundle is not accepted. Then clear_i -> full_o=0, count_o=0, next write goes to addr 0.
- Assert rst_i during ENC, or clear_i during WRITE entry -> no mem_we_o pulse; all outputs at reset values; the next accepted bundle writes to addr 0.
